// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the fetch PC, arbitrates jump/branch/register redirects,
// generates pipeline flushes, gates advance for debug stepping and drains on HALT.
module pc_sequencer #(
  parameter int unsigned       NBITS        = 32,
  parameter int unsigned       SELBITS      = 2,
  parameter logic [NBITS-1:0]  RESET_PC     = '0,
  parameter int unsigned       DRAIN_CYCLES = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               run_mode,
  input  logic               step,
  input  logic               stall,
  input  logic               halt_id,
  input  logic               jump_id,
  input  logic               jreg_id,
  input  logic               branch_ex,
  input  logic [NBITS-1:0]   branch_addr,
  input  logic [NBITS-1:0]   jump_addr,
  input  logic [NBITS-1:0]   reg_addr,
  output logic [NBITS-1:0]   pc,
  output logic [SELBITS-1:0] sel_addr,
  output logic               redirect,
  output logic               flush_if_id,
  output logic               flush_id_ex,
  output logic               pipe_en,
  output logic               halted
);
  localparam int unsigned CW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [SELBITS-1:0] SEL_JMP  = SELBITS'(0);
  localparam logic [SELBITS-1:0] SEL_BR   = SELBITS'(1);
  localparam logic [SELBITS-1:0] SEL_REG  = SELBITS'(2);
  localparam logic [SELBITS-1:0] SEL_NONE = SELBITS'(3);

  typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

  state_t           state_q, state_d;
  logic [NBITS-1:0] pc_q, pc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             adv;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are held quiet while reset is asserted, independent of stored state.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    cnt_d       = cnt_q;
    sel_addr    = SEL_NONE;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    adv         = rst_n && (state_q != HALTED) && (run_mode || step);
    if (adv && state_q == RUN) begin
      if (branch_ex) begin
        sel_addr    = SEL_BR;
        pc_d        = branch_addr;
        flush_if_id = 1'b1;
        flush_id_ex = 1'b1;
      end else if (stall) begin
        pc_d = pc_q;
      end else if (jump_id) begin
        sel_addr    = SEL_JMP;
        pc_d        = jump_addr;
        flush_if_id = 1'b1;
      end else if (jreg_id) begin
        sel_addr    = SEL_REG;
        pc_d        = reg_addr;
        flush_if_id = 1'b1;
      end else if (halt_id) begin
        flush_if_id = 1'b1;
        state_d     = DRAIN;
        cnt_d       = '0;
      end else begin
        pc_d = pc_q + NBITS'(4);
      end
    end else if (adv && state_q == DRAIN) begin
      flush_if_id = 1'b1;
      cnt_d       = cnt_q + CW'(1);
      state_d     = (cnt_q == CW'(DRAIN_CYCLES - 1)) ? HALTED : DRAIN;
    end
  end

  assign pc       = pc_q;
  assign redirect = (sel_addr != SEL_NONE);
  assign pipe_en  = adv;
  assign halted   = rst_n && (state_q == HALTED);
endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed self-checking bench for pc_sequencer with
// hand-computed expectations for redirects, stalls, drain/halt, stepping and reset.
module tb_pc_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, run_mode, step, stall, halt_id, jump_id, jreg_id, branch_ex;
  logic [31:0] branch_addr, jump_addr, reg_addr, pc;
  logic [1:0]  sel_addr;
  logic        redirect, flush_if_id, flush_id_ex, pipe_en, halted;
  int          passed = 0;
  int          total  = 0;

  pc_sequencer dut (
    .clk(clk), .rst_n(rst_n), .run_mode(run_mode), .step(step), .stall(stall),
    .halt_id(halt_id), .jump_id(jump_id), .jreg_id(jreg_id), .branch_ex(branch_ex),
    .branch_addr(branch_addr), .jump_addr(jump_addr), .reg_addr(reg_addr),
    .pc(pc), .sel_addr(sel_addr), .redirect(redirect), .flush_if_id(flush_if_id),
    .flush_id_ex(flush_id_ex), .pipe_en(pipe_en), .halted(halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic comb(input string tag, input logic [1:0] s, input logic fi, input logic fe,
                      input logic pe);
    chk({tag, ".sel"}, 32'(sel_addr), 32'(s));
    chk({tag, ".redirect"}, 32'(redirect), 32'(s != 2'b11));
    chk({tag, ".flush_if_id"}, 32'(flush_if_id), 32'(fi));
    chk({tag, ".flush_id_ex"}, 32'(flush_id_ex), 32'(fe));
    chk({tag, ".pipe_en"}, 32'(pipe_en), 32'(pe));
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr;
    {step, stall, halt_id, jump_id, jreg_id, branch_ex} = '0;
  endtask

  initial begin
    rst_n = 1'b0; run_mode = 1'b1; clr();
    branch_addr = '0; jump_addr = '0; reg_addr = '0;
    #1;
    comb("rst_forced", 2'b11, 0, 0, 0);
    chk("rst_halted", 32'(halted), 0);
    tick();
    chk("rst_pc", pc, 32'h0);
    rst_n = 1'b1;
    #1;
    comb("seq0", 2'b11, 0, 0, 1);
    for (int i = 1; i <= 4; i++) begin
      tick();
      chk($sformatf("seq_pc%0d", i), pc, 32'(4 * i));
    end
    // pc = 0x10: jump
    jump_id = 1; jump_addr = 32'h100; #1;
    comb("jump", 2'b00, 1, 0, 1);
    tick(); clr();
    chk("jump_pc", pc, 32'h100);
    // branch beats stall and jump
    branch_ex = 1; branch_addr = 32'h40; jump_id = 1; stall = 1; #1;
    comb("branch", 2'b01, 1, 1, 1);
    tick(); clr();
    chk("branch_pc", pc, 32'h40);
    jump_id = 1; jump_addr = 32'h20; tick(); clr();
    chk("to20_pc", pc, 32'h20);
    // stall masks jreg
    stall = 1; jreg_id = 1; reg_addr = 32'h80; #1;
    comb("stall1", 2'b11, 0, 0, 1);
    tick();
    chk("stall1_pc", pc, 32'h20);
    tick();
    chk("stall2_pc", pc, 32'h20);
    stall = 0; #1;
    comb("jreg", 2'b10, 1, 0, 1);
    tick(); clr();
    chk("jreg_pc", pc, 32'h80);
    // jump beats jreg
    jump_id = 1; jump_addr = 32'h200; jreg_id = 1; #1;
    comb("jump_vs_jreg", 2'b00, 1, 0, 1);
    tick(); clr();
    chk("jump_vs_jreg_pc", pc, 32'h200);
    // wrap
    jump_id = 1; jump_addr = 32'hFFFF_FFFC; tick(); clr();
    chk("pre_wrap_pc", pc, 32'hFFFF_FFFC);
    tick();
    chk("wrap_pc", pc, 32'h0);
    jump_id = 1; jump_addr = 32'h30; tick(); clr();
    chk("to30_pc", pc, 32'h30);
    // halt and drain; wrong-path events ignored during drain
    halt_id = 1; #1;
    comb("halt", 2'b11, 1, 0, 1);
    tick(); clr();
    branch_ex = 1; jump_id = 1; stall = 1;
    for (int i = 1; i <= 3; i++) begin
      chk($sformatf("drain%0d_pc", i), pc, 32'h30);
      chk($sformatf("drain%0d_halted", i), 32'(halted), 0);
      #1;
      comb($sformatf("drain%0d", i), 2'b11, 1, 0, 1);
      tick();
    end
    clr();
    #1;
    chk("halted", 32'(halted), 1);
    chk("halted_pc", pc, 32'h30);
    comb("halted", 2'b11, 0, 0, 0);
    tick();
    chk("halted_stay_pc", pc, 32'h30);
    chk("halted_stay", 32'(halted), 1);
    // reset out of HALTED
    rst_n = 0; #1;
    chk("rst2_halted", 32'(halted), 0);
    comb("rst2", 2'b11, 0, 0, 0);
    tick(); rst_n = 1;
    chk("rst2_pc", pc, 32'h0);
    // single-step: pulses at cycles 2 and 5
    run_mode = 0;
    for (int i = 0; i < 7; i++) begin
      step = (i == 2 || i == 5); #1;
      chk($sformatf("step%0d_pe", i), 32'(pipe_en), 32'(i == 2 || i == 5));
      tick();
      chk($sformatf("step%0d_pc", i), pc, (i >= 5) ? 32'h8 : (i >= 2) ? 32'h4 : 32'h0);
    end
    step = 0;
    // step into drain, then reset mid-drain
    halt_id = 1; step = 1; tick(); clr();
    step = 1; #1;
    comb("step_drain", 2'b11, 1, 0, 1);
    tick(); step = 0;
    chk("step_drain_pc", pc, 32'h8);
    rst_n = 0; tick(); rst_n = 1;
    chk("rst3_pc", pc, 32'h0);
    chk("rst3_halted", 32'(halted), 0);
    run_mode = 1; #1;
    comb("rst3_run", 2'b11, 0, 0, 1);
    tick();
    chk("rst3_adv_pc", pc, 32'h4);
    tick();
    chk("rst3_adv2_pc", pc, 32'h8);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
